mfp_spi_slave_regs: RTL
=======================

Name: mfp_spi_slave_regs

Overview:
- Synthesizable SPI slave register bank that sits directly downstream of the MIPSfpga system's SPI master pins (SPI_SS, SPI_SCLK, SPI_MOSI, SPI_MISO).
- It is the device the SPI master talks to, both in simulation and on the board.
- It decodes a command byte, then auto-increments through a small byte-wide register file for burst reads and writes.
- A host-side read port and write-strobe outputs let the testbench or other logic observe register contents and SPI activity.

Parameters:
- ADDR_W, 4, register file address width; the file holds 2^ADDR_W bytes.
- ID_BYTE, 8'h5A, byte shifted out on MISO during every command byte.

Ports:
- HCLK  input  1  system clock; all logic is on the rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- SPI_SS  input  1  slave select, active low, asynchronous to HCLK.
- SPI_SCLK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to HCLK.
- SPI_MOSI  input  1  serial data in, MSB first.
- SPI_MISO  output  1  serial data out, MSB first.
- host_addr  input  ADDR_W  host read address.
- host_rdata  output  8  regs[host_addr], registered.
- wr_strobe  output  1  one-HCLK pulse per completed SPI write byte.
- wr_addr  output  ADDR_W  address of that write; valid while wr_strobe=1.
- wr_data  output  8  data of that write; valid while wr_strobe=1.
- xfer_count  output  16  count of completed data bytes (reads and writes); wraps at 16'hFFFF to 0.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - SPI_MISO=0, host_rdata=0, wr_strobe=0, wr_addr=0, wr_data=0, xfer_count=0, busy=0.
  - All register file bytes = 0; state IDLE; bit counter 0.
- Synchronization:
  - SPI_SS, SPI_SCLK and SPI_MOSI each pass through 2-flop synchronizers.
  - SCLK rise/fall events are detected on the synchronized SCLK with one extra flop.
  - Required: SCLK high and low phases each >= 4 HCLK cycles; SS setup to the first SCLK rise >= 4 HCLK cycles.
- Bit timing:
  - MOSI is sampled on the synchronized SCLK rise.
  - The tx shift register advances on the synchronized SCLK fall.
  - SPI_MISO = tx_shift[7] while SS is low, 0 while SS is high.
  - Bit counter 0..7 increments on each rise; byte complete at the 8th rise.
- States:
  - IDLE: SS falls -> CMD, bit counter=0, tx_shift=ID_BYTE.
  - CMD: on byte complete, cmd[6:0] truncated to ADDR_W loads the address pointer.
    - cmd[7]=1 -> WDATA; tx_shift loaded with 8'h00 at the next SCLK fall.
    - cmd[7]=0 -> RDATA; tx_shift=regs[ptr] loaded at the next SCLK fall, so bit 7 is valid before the next rise.
  - WDATA: on byte complete, regs[ptr]<=byte in the same HCLK.
    - wr_strobe=1 for exactly one HCLK, with wr_addr=ptr and wr_data=byte.
    - ptr<=ptr+1 modulo 2^ADDR_W; xfer_count++.
    - tx_shift<=0.
  - RDATA: on byte complete, ptr<=ptr+1 modulo 2^ADDR_W and xfer_count++.
    - At the next SCLK fall, tx_shift<=regs[new ptr].
    - MOSI data is ignored.
- SS rise in any state (synchronized):
  - Go to IDLE; bit counter=0; any partial byte is discarded (no write, no strobe, no count).
  - A byte completed on the same HCLK as the SS-rise detection is still committed.
  - SS rise during CMD ends the transaction with no effect.
- host_rdata:
  - Updated every HCLK with regs[host_addr], so latency is 1 cycle.
  - If an SPI write to the same address commits in the same cycle, host_rdata shows the old value; the new value appears one cycle later.
- Asynchronous reset mid-transaction:
  - Immediate return to the reset values above.
  - After release, the slave waits for a fresh SS fall; a transaction already in progress (SS held low) is ignored until SS goes high and falls again.

Test Plan:
- Reset hold 20 cycles with SS=1: MISO=0, busy=0, xfer_count=0, host_rdata=0 for host_addr 0..15.
- Write burst, SS low, bytes 0x85,0x11,0x22, SS high:
  - MISO during the first byte = 0x5A.
  - Two wr_strobe pulses: (addr 5, 0x11) then (addr 6, 0x22).
  - host_rdata reads 0x11 at address 5 and 0x22 at address 6; xfer_count=2.
- Read burst 0x05,0xFF,0xFF after the write burst: MISO bytes = 0x5A, 0x11, 0x22; no wr_strobe; xfer_count=4.
- Wrap with ADDR_W=4, write 0x8F,0xAA,0xBB: regs[15]=0xAA and regs[0]=0xBB. Command 0xFF maps to address 15.
- Abort:
  - Write 0x83 then 4 bits of 0xC3, then SS high: regs[3] unchanged, no strobe, xfer_count unchanged, busy=0.
  - A following write 0x83,0x77 gives regs[3]=0x77.
- Reset mid-burst:
  - Assert HRESETn=0 after the command byte of a write burst: all registers read 0.
  - SCLK edges while SS is still low produce no strobes.
  - A new SS fall restarts normal operation.

Source files
------------

// File: rtl/mfp_spi_slave_regs.sv
// SPI mode-0 slave with a byte-wide register file: command byte selects
// read/write and start address, data bytes auto-increment through the file.
module mfp_spi_slave_regs #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  ID_BYTE = 8'h5A
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              SPI_SS,
    input  logic              SPI_SCLK,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [15:0]       xfer_count,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // Synchronizers reset low so an SS already held low at reset release never looks like a fall
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [1:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              load_pend_q, load_pend_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        regs_q [DEPTH];
    logic [7:0]        regs_d [DEPTH];
    logic              miso_q, miso_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [15:0]       xfer_count_q, xfer_count_d;
    logic              busy_q, busy_d;
    logic [7:0]        rx_byte;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_fall   =  ss_prev_q   & ~ss_sync_q;
    assign ss_rise   = ~ss_prev_q   &  ss_sync_q;
    assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
    assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ss_meta_q    <= 1'b0;
            ss_sync_q    <= 1'b0;
            ss_prev_q    <= 1'b0;
            sclk_meta_q  <= 1'b0;
            sclk_sync_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            mosi_meta_q  <= 1'b0;
            mosi_sync_q  <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            load_pend_q  <= 1'b0;
            ptr_q        <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            miso_q       <= 1'b0;
            host_rdata_q <= '0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            xfer_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            ss_meta_q    <= SPI_SS;
            ss_sync_q    <= ss_meta_q;
            ss_prev_q    <= ss_sync_q;
            sclk_meta_q  <= SPI_SCLK;
            sclk_sync_q  <= sclk_meta_q;
            sclk_prev_q  <= sclk_sync_q;
            mosi_meta_q  <= SPI_MOSI;
            mosi_sync_q  <= mosi_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            load_pend_q  <= load_pend_d;
            ptr_q        <= ptr_d;
            regs_q       <= regs_d;
            miso_q       <= miso_d;
            host_rdata_q <= host_rdata_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            xfer_count_q <= xfer_count_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        load_pend_d  = load_pend_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        xfer_count_d = xfer_count_q;
        rx_byte      = {rx_q, mosi_sync_q};

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d     = ST_CMD;
                    bit_cnt_d   = '0;
                    tx_d        = ID_BYTE;
                    load_pend_d = 1'b0;
                end
            end
            default: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_CMD: begin
                                ptr_d       = ADDR_W'(rx_byte[6:0]);
                                state_d     = rx_byte[7] ? ST_WDATA : ST_RDATA;
                                load_pend_d = 1'b1;
                            end
                            ST_WDATA: begin
                                regs_d[ptr_q] = rx_byte;
                                wr_strobe_d   = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = rx_byte;
                                ptr_d         = ptr_q + ADDR_W'(1);
                                xfer_count_d  = xfer_count_q + 16'd1;
                                tx_d          = '0;
                            end
                            default: begin
                                ptr_d        = ptr_q + ADDR_W'(1);
                                xfer_count_d = xfer_count_q + 16'd1;
                                load_pend_d  = 1'b1;
                            end
                        endcase
                    end
                end
                // After a completed byte the next fall reloads tx instead of shifting
                if (sclk_fall) begin
                    if (load_pend_q) begin
                        tx_d        = (state_q == ST_RDATA) ? regs_q[ptr_q] : 8'h00;
                        load_pend_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                    tx_d        = '0;
                end
            end
        endcase

        miso_d       = ~ss_sync_q & tx_d[7];
        busy_d       = (state_d != ST_IDLE);
        host_rdata_d = regs_q[host_addr];
    end

    assign SPI_MISO   = miso_q;
    assign host_rdata = host_rdata_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign xfer_count = xfer_count_q;
    assign busy       = busy_q;

endmodule
